// File: rtl/apb_pkg.sv
// Shared APB completer definitions: bus widths and slave FSM state encoding.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_S_IDLE,
    ST_S_WAIT,
    ST_S_RESP
  } apb_slv_state_t;

endpackage

// File: rtl/apb_regfile_core.sv
// Register array, address decode, error flag, read mux and completed-transfer counter.
module apb_regfile_core
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'hA000
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [APB_ADDR_W-1:0]   addr_i,
  input  logic                    write_i,
  input  logic [APB_DATA_W-1:0]   wdata_i,
  input  logic                    commit_i,
  output logic [APB_DATA_W-1:0]   rdata_o,
  output logic                    err_o,
  output logic [NUM_REGS*32-1:0]  reg_q_o
);

  logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
  logic [APB_CNT_W-1:0]  cnt_q;
  logic [APB_ADDR_W-1:0] offset;
  logic [APB_ADDR_W-1:0] idx;
  logic                  aligned;
  logic                  is_reg;
  logic                  is_cnt;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  always_comb begin
    offset  = addr_i - BASE_ADDR;
    idx     = offset >> 2;
    aligned = (addr_i[1:0] == 2'b00);
    is_reg  = aligned && (idx < 32'(NUM_REGS));
    is_cnt  = aligned && (idx == 32'(NUM_REGS));
    err_o   = !is_reg && !(is_cnt && !write_i);
  end

  always_comb begin
    rdata_o = '0;
    if (is_cnt) begin
      rdata_o = {{(APB_DATA_W-APB_CNT_W){1'b0}}, cnt_q};
    end
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (is_reg && (idx == 32'(i))) begin
        rdata_o = regs_q[i];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_i && !err_o) begin
      cnt_q <= cnt_q + 16'd1;
      if (write_i && is_reg) begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
          if (idx == 32'(i)) begin
            regs_q[i] <= wdata_i;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_out
    assign reg_q_o[g*32 +: 32] = regs_q[g];
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer: transfer FSM with programmable wait states in front of the register bank.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'hA000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic [APB_ADDR_W-1:0]  paddr_i,
  input  logic                   pwrite_i,
  input  logic [APB_DATA_W-1:0]  pwdata_i,
  output logic [APB_DATA_W-1:0]  prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic [NUM_REGS*32-1:0] reg_q_o
);

  localparam logic [3:0] WaitLd = 4'(WAIT_CYCLES);

  apb_slv_state_t        state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [APB_DATA_W-1:0] rdata;
  logic                  err;
  logic                  commit;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_S_IDLE: begin
        if (psel_i && penable_i) begin
          addr_d  = paddr_i;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          wcnt_d  = WaitLd;
          state_d = (WAIT_CYCLES > 0) ? ST_S_WAIT : ST_S_RESP;
        end
      end
      ST_S_WAIT: begin
        if (!psel_i) begin
          state_d = ST_S_IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_d = ST_S_RESP;
          end
        end
      end
      ST_S_RESP: state_d = ST_S_IDLE;
      default:   state_d = ST_S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= ST_S_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // A master dropping psel in RESP aborts: nothing is written or counted.
  assign commit    = (state_q == ST_S_RESP) && psel_i;
  assign pready_o  = (state_q == ST_S_RESP);
  assign pslverr_o = pready_o && err;
  assign prdata_o  = (pready_o && !err && !write_q) ? rdata : '0;

  apb_regfile_core #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_core (
    .pclk     (pclk),
    .preset   (preset),
    .addr_i   (addr_q),
    .write_i  (write_q),
    .wdata_i  (wdata_q),
    .commit_i (commit),
    .rdata_o  (rdata),
    .err_o    (err),
    .reg_q_o  (reg_q_o)
  );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: one instance with no wait states and one with three.
module tb_apb_regfile_slave;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'hA000;
  localparam logic [31:0] CNTA = BASE + 32'(4 * N);

  logic            pclk = 1'b0;
  logic            preset = 1'b0;
  logic            psel    [2];
  logic            penable [2];
  logic [31:0]     paddr   [2];
  logic            pwrite  [2];
  logic [31:0]     pwdata  [2];
  logic [31:0]     prdata  [2];
  logic            pready  [2];
  logic            pslverr [2];
  logic [N*32-1:0] reg_q   [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [2][N];
  logic [15:0] m_cnt  [2];
  int          exp_cyc [2] = '{2, 5};

  always #5 pclk = ~pclk;

  apb_regfile_slave #(.NUM_REGS(N), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel_i(psel[0]), .penable_i(penable[0]),
    .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]), .reg_q_o(reg_q[0])
  );

  apb_regfile_slave #(.NUM_REGS(N), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel_i(psel[1]), .penable_i(penable[1]),
    .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]), .reg_q_o(reg_q[1])
  );

  // Reference model: decodes the address map directly from the documented rules.
  function automatic void model(input int w, input logic [31:0] a, input logic wr,
                                input logic [31:0] d, output logic [31:0] rd,
                                output logic er);
    longint off;
    off = longint'(a) - longint'(BASE);
    rd  = '0;
    er  = 1'b0;
    if (a % 4 != 0 || off < 0 || off > 4 * N) er = 1'b1;
    else if (off == 4 * N) begin
      if (wr) er = 1'b1;
      else rd = {16'h0, m_cnt[w]};
    end else if (wr) m_regs[w][int'(off / 4)] = d;
    else rd = m_regs[w][int'(off / 4)];
    if (!er) m_cnt[w] = m_cnt[w] + 16'd1;
  endfunction

  function automatic logic [N*32-1:0] model_regs(input int w);
    logic [N*32-1:0] r;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = m_regs[w][i];
    return r;
  endfunction

  task automatic do_reset();
    @(posedge pclk); #1;
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = '0;
      for (int i = 0; i < N; i++) m_regs[w][i] = '0;
    end
  endtask

  // One SETUP+ACCESS transfer; cyc counts ACCESS cycles up to and including pready.
  task automatic xfer(input int w, input logic [31:0] a, input logic wr, input logic [31:0] d,
                      input bit toggle, output logic [31:0] rd, output logic er,
                      output int cyc);
    bit done;
    done = 1'b0;
    @(posedge pclk); #1;
    psel[w] = 1'b1; penable[w] = 1'b0; paddr[w] = a; pwrite[w] = wr; pwdata[w] = d;
    @(posedge pclk); #1;
    penable[w] = 1'b1;
    cyc = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge pclk);
      cyc++;
      if (pready[w]) begin
        rd = prdata[w]; er = pslverr[w]; done = 1'b1;
      end else if (toggle && cyc >= 2) begin
        paddr[w] = $urandom; pwdata[w] = $urandom;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout dut=%0d addr=%h: pready never rose, required within 40", w, a);
    end
    @(posedge pclk); #1;
    psel[w] = 1'b0; penable[w] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int w = 0; w < 2; w++) begin
      n_tests++;
      if ({pready[w], pslverr[w], prdata[w], reg_q[w]} !== '0) begin
        n_fail++;
        $display("FAIL reset dut=%0d: pready=%b pslverr=%b prdata=%h reg_q=%h, required all 0",
                 w, pready[w], pslverr[w], prdata[w], reg_q[w]);
      end
    end
  endtask

  task automatic test_first_read();
    logic [31:0] rd, erd; logic er, eer; int cyc;
    xfer(0, BASE, 1'b0, 32'h0, 1'b0, rd, er, cyc);
    model(0, BASE, 1'b0, 32'h0, erd, eer);
    n_tests++;
    if (cyc !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL first_read: cyc=%0d rd=%h err=%b, required cyc=2 rd=0 err=0", cyc, rd, er);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, erd; logic er, eer; int cyc;
    xfer(0, BASE + 32'h4, 1'b1, 32'hDEADBEEF, 1'b0, rd, er, cyc);
    model(0, BASE + 32'h4, 1'b1, 32'hDEADBEEF, erd, eer);
    n_tests++;
    if (reg_q[0][63:32] !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL write_visible: reg1=%h err=%b, required DEADBEEF 0", reg_q[0][63:32], er);
    end
    n_tests++;
    if (reg_q[0] !== model_regs(0)) begin
      n_fail++;
      $display("FAIL write_slices: reg_q=%h, required %h", reg_q[0], model_regs(0));
    end
    xfer(0, BASE + 32'h4, 1'b0, 32'h0, 1'b0, rd, er, cyc);
    model(0, BASE + 32'h4, 1'b0, 32'h0, erd, eer);
    n_tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL write_readback: rd=%h err=%b, required DEADBEEF 0", rd, er);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; logic er, eer; int cyc;
    xfer(1, BASE + 32'h8, 1'b1, 32'hA5A5_0F0F, 1'b1, rd, er, cyc);
    model(1, BASE + 32'h8, 1'b1, 32'hA5A5_0F0F, erd, eer);
    xfer(1, BASE + 32'h8, 1'b0, 32'h0, 1'b1, rd, er, cyc);
    model(1, BASE + 32'h8, 1'b0, 32'h0, erd, eer);
    n_tests++;
    if (cyc !== 5 || rd !== erd || er !== eer) begin
      n_fail++;
      $display("FAIL wait_read: cyc=%0d rd=%h err=%b, required cyc=5 rd=%h err=%b",
               cyc, rd, er, erd, eer);
    end
    n_tests++;
    if (reg_q[1] !== model_regs(1)) begin
      n_fail++;
      $display("FAIL wait_regs: reg_q=%h, required %h", reg_q[1], model_regs(1));
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic [31:0] rd, erd; logic er, eer; int cyc;
    addrs = '{BASE + 32'h2, BASE + 32'h100, CNTA};
    for (int i = 0; i < 3; i++) begin
      xfer(0, addrs[i], 1'b1, 32'hFFFF_FFFF, 1'b0, rd, er, cyc);
      model(0, addrs[i], 1'b1, 32'hFFFF_FFFF, erd, eer);
      n_tests++;
      if (er !== 1'b1 || reg_q[0] !== model_regs(0)) begin
        n_fail++;
        $display("FAIL err_write addr=%h: err=%b reg_q=%h, required err=1 reg_q=%h",
                 addrs[i], er, reg_q[0], model_regs(0));
      end
    end
    xfer(0, BASE + 32'h100, 1'b0, 32'h0, 1'b0, rd, er, cyc);
    model(0, BASE + 32'h100, 1'b0, 32'h0, erd, eer);
    n_tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL err_read: rd=%h err=%b, required rd=0 err=1", rd, er);
    end
  endtask

  task automatic test_counter();
    logic [31:0] rd, erd; logic er, eer; int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = (i == 3) ? BASE + 32'h1 : BASE + 32'(4 * i);
      xfer(0, a, 1'(i % 2), 32'(i), 1'b0, rd, er, cyc);
      model(0, a, 1'(i % 2), 32'(i), erd, eer);
    end
    for (int k = 0; k < 2; k++) begin
      xfer(0, CNTA, 1'b0, 32'h0, 1'b0, rd, er, cyc);
      model(0, CNTA, 1'b0, 32'h0, erd, eer);
      n_tests++;
      if (rd !== 32'(3 + k) || er !== 1'b0) begin
        n_fail++;
        $display("FAIL cnt_read%0d: rd=%h err=%b, required rd=%0d err=0", k, rd, er, 3 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int cyc;
    @(posedge pclk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = BASE; pwrite[1] = 1'b1;
    pwdata[1] = 32'h12345678;
    @(posedge pclk); #1 penable[1] = 1'b1;
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk); #1;
    n_tests++;
    if (pready[1] !== 1'b0 || reg_q[1] !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: pready=%b reg_q=%h, required 0 0", pready[1], reg_q[1]);
    end
    preset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = '0;
      for (int i = 0; i < N; i++) m_regs[w][i] = '0;
    end
    xfer(1, BASE, 1'b0, 32'h0, 1'b0, rd, er, cyc);
    model(1, BASE, 1'b0, 32'h0, erd, eer);
    n_tests++;
    if (cyc !== 5 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: cyc=%0d rd=%h err=%b, required 5 0 0", cyc, rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eer, wr; int cyc, w;
    for (int t = 0; t < 60; t++) begin
      w  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    a = BASE + 32'(4 * $urandom_range(0, N - 1));
        2:       a = CNTA;
        3:       a = BASE + 32'(4 * $urandom_range(0, N - 1)) + 32'($urandom_range(1, 3));
        default: a = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 : CNTA + 32'h4;
      endcase
      xfer(w, a, wr, d, 1'($urandom_range(0, 1)), rd, er, cyc);
      model(w, a, wr, d, erd, eer);
      n_tests++;
      if (cyc !== exp_cyc[w] || er !== eer || (!wr && rd !== erd)) begin
        n_fail++;
        $display("FAIL rand%0d dut=%0d addr=%h wr=%b: cyc=%0d rd=%h err=%b, required %0d %h %b",
                 t, w, a, wr, cyc, rd, er, exp_cyc[w], erd, eer);
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (reg_q[k] !== model_regs(k)) begin
        n_fail++;
        $display("FAIL rand_regs dut=%0d: reg_q=%h, required %h", k, reg_q[k], model_regs(k));
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      psel[w] = 1'b0; penable[w] = 1'b0; paddr[w] = '0; pwrite[w] = 1'b0; pwdata[w] = '0;
    end
    test_reset();
    test_first_read();
    test_write_read();
    test_wait_states();
    test_errors();
    test_counter();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
APB completer: a word-addressed register bank with a configurable number of wait states, error response and a read-only transfer counter.
It is the responder end of the APB links driven by our APB masters, including the adder master that reads, increments and writes back 0xA000.
It replaces the single-register test slave for system-level runs.

Parameters:
NUM_REGS, 4, number of 32-bit read/write registers (1..16)
BASE_ADDR, 32'hA000, byte address of register 0; must be 4-byte aligned
WAIT_CYCLES, 0, extra pready-low cycles inserted in the ACCESS phase (0..15)

Ports:
pclk  input  1  clock; all logic on the rising edge
preset  input  1  synchronous, active-high reset
psel_i  input  1  APB select
penable_i  input  1  APB enable
paddr_i  input  32  APB byte address
pwrite_i  input  1  1 = write, 0 = read
pwdata_i  input  32  write data
prdata_o  output  32  read data; valid only while pready_o=1
pready_o  output  1  transfer-complete strobe
pslverr_o  output  1  error response; valid only while pready_o=1
reg_q_o  output  NUM_REGS*32  live register contents; slice i = register i

Behaviour:
- Interface: one clock (pclk). Reset (preset) is synchronous and active-high.
- Reset: state=IDLE; pready_o, pslverr_o, prdata_o, all registers, wait counter and transfer counter = 0. Reset has priority over everything, including mid-transfer.
- Address map:
  - Register i is at BASE_ADDR+4*i.
  - CNT (read-only, 16-bit, zero-extended) is at BASE_ADDR+4*NUM_REGS.
  - Any other address, or paddr_i[1:0]!=0, is an error.
  - A write to CNT is an error.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: if psel_i&penable_i, latch paddr_i, pwrite_i and pwdata_i and load wcnt=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else RESP. The SETUP cycle (psel_i&~penable_i) is ignored.
  - WAIT: decrement wcnt; go to RESP when wcnt==1.
  - RESP: pready_o=1 for exactly one cycle, then IDLE.
- Outputs are decoded from the registered state. ACCESS phase length = WAIT_CYCLES+2 cycles; pready_o is low for the first WAIT_CYCLES+1 of them.
- RESP, read: prdata_o = addressed value, or 0 on error.
- RESP, write: the register updates on the edge ending RESP. It is visible on reg_q_o and on reads from the next cycle.
- On error: pslverr_o=1, no state change, prdata_o=0.
- Outside RESP: prdata_o=0 and pslverr_o=0.
- CNT increments by 1 on the edge ending RESP of every non-error transfer and wraps 0xFFFF->0. A read of CNT returns the value before its own increment.
- Abort: if psel_i drops while in WAIT or RESP (a master protocol violation), go to IDLE next cycle. No write, no count, pready_o=0.
- After RESP there is always at least one IDLE cycle before a new transfer is accepted, so back-to-back transfers cost SETUP+ACCESS each.
- Latched address and data are used, not live inputs, so changes on paddr_i or pwdata_i during wait states are ignored.

Decomposition:
- Shared package apb_pkg holds:
  - apb_slv_state_t {ST_S_IDLE, ST_S_WAIT, ST_S_RESP}
  - APB_ADDR_W=32, APB_DATA_W=32, APB_CNT_W=16
- One sub-module, apb_regfile_core, contains the register array, address decode, error flag, read mux and CNT.
- apb_regfile_slave contains the FSM, wait counter and APB output regs.

Test Plan:
1. Reset, then read 0xA000 (WAIT_CYCLES=0) -> pready_o high in the 2nd ACCESS cycle; prdata_o=0; pslverr_o=0.
2. Write 0xDEADBEEF to 0xA004, then read 0xA004 -> read returns 0xDEADBEEF; reg_q_o[63:32]=0xDEADBEEF from the cycle after the write's RESP; other slices 0.
3. Build with WAIT_CYCLES=3, read 0xA008 -> ACCESS lasts 5 cycles; pready_o low for 4 then high for 1; toggling paddr_i in wait cycles has no effect.
4. Write to 0xA002, to 0xA100 and to 0xA010 (CNT) -> pslverr_o=1 for each; registers unchanged; read of 0xA100 gives prdata_o=0, pslverr_o=1.
5. Three good transfers, one errored, then read 0xA010 -> prdata_o=3; a following read -> 4.
6. Assert preset in WAIT during a write of 0x12345678 to 0xA000 -> next cycle pready_o=0 and reg_q_o=0; a new read of 0xA000 completes normally with 0.
